regfile_wb_scheduler: RTL

- Schedules the single write port of the 32x64 register file between two writeback requesters: the ALU result path and the load/memory result path.
- Tracks in-flight destination registers with a busy scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the register file.
- Drives the register file's RegWrite, rd and wrt_data inputs from a registered output stage.

---
 rtl/regfile_wb_scheduler_if.sv | 19 +
 rtl/regfile_wb_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - writeback request bundle (valid/ready/rd/data)
// Purpose: one writeback requester's handshake towards the scheduler.
// Signals:
//   valid  requester -> scheduler  request present
//   ready  scheduler -> requester  request accepted this cycle
//   rd     requester -> scheduler  destination register index
//   data   requester -> scheduler  writeback value
interface regfile_wb_scheduler_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 64
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] data;

   modport master (output valid, output rd, output data, input ready);
   modport slave  (input valid, input rd, input data, output ready);
endinterface

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register file write-port arbiter with busy scoreboard
// Purpose: arbitrates the single register file write port between the ALU and
// load writeback paths, registers the chosen write, and tracks in-flight
// destination registers so decode can stall on RAW hazards.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   io_alu, io_mem      writeback requesters (slave side of the bundle)
//   i_issue_valid/rd    decode issues a producer of rd
//   i_chk_rs1/rs2       decode source registers to check
//   o_stall             a checked source is busy
//   o_rf_we/rd/wdata    registered register file write port
//   o_idx_err           sticky out-of-range index flag
module regfile_wb_scheduler #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   regfile_wb_scheduler_if.slave io_alu,
   regfile_wb_scheduler_if.slave io_mem,
   input  logic                  i_issue_valid,
   input  logic [ADDR_W-1:0]     i_issue_rd,
   input  logic [ADDR_W-1:0]     i_chk_rs1,
   input  logic [ADDR_W-1:0]     i_chk_rs2,
   output logic                  o_stall,
   output logic                  o_rf_we,
   output logic [ADDR_W-1:0]     o_rf_rd,
   output logic [DATA_W-1:0]     o_rf_wdata,
   output logic                  o_idx_err
);

   localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

   // Round-robin pointer: names the requester that wins the next tie.
   typedef enum logic {PTR_MEM = 1'b0, PTR_ALU = 1'b1} ptr_t;

   ptr_t                r_ptr;
   ptr_t                w_ptr_nxt;
   logic                w_alu_gnt;
   logic                w_mem_gnt;
   logic                w_accept;
   logic [ADDR_W-1:0]   w_sel_rd;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_sel_in_range;
   logic                w_issue_in_range;
   logic                w_wr_en;
   logic                w_issue_set;

   logic                r_rf_we;
   logic [ADDR_W-1:0]   r_rf_rd;
   logic [DATA_W-1:0]   r_rf_wdata;
   logic                r_idx_err;
   logic [NUM_REGS-1:0] r_busy;
   logic                w_stall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= PTR_MEM;
      end else begin
         r_ptr <= w_ptr_nxt;
      end
   end

   // Grants depend only on the valids and the pointer; the pointer moves
   // only when both requesters compete.
   always_comb begin
      w_alu_gnt = 1'b0;
      w_mem_gnt = 1'b0;
      w_ptr_nxt = r_ptr;
      if (io_alu.valid && io_mem.valid) begin
         if (r_ptr == PTR_ALU) begin
            w_alu_gnt = 1'b1;
            w_ptr_nxt = PTR_MEM;
         end else begin
            w_mem_gnt = 1'b1;
            w_ptr_nxt = PTR_ALU;
         end
      end else begin
         w_alu_gnt = io_alu.valid;
         w_mem_gnt = io_mem.valid;
      end
   end

   assign io_alu.ready = w_alu_gnt;
   assign io_mem.ready = w_mem_gnt;

   assign w_accept         = w_alu_gnt | w_mem_gnt;
   assign w_sel_rd         = w_alu_gnt ? io_alu.rd   : io_mem.rd;
   assign w_sel_data       = w_alu_gnt ? io_alu.data : io_mem.data;
   assign w_sel_in_range   = ({1'b0, w_sel_rd} < LP_NUM_REGS);
   assign w_issue_in_range = ({1'b0, i_issue_rd} < LP_NUM_REGS);
   // x0 and out-of-range writes still handshake but never reach the file.
   assign w_wr_en          = w_accept && w_sel_in_range && (w_sel_rd != '0);
   assign w_issue_set      = i_issue_valid && w_issue_in_range && (i_issue_rd != '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rf_we    <= 1'b0;
         r_rf_rd    <= '0;
         r_rf_wdata <= '0;
         r_idx_err  <= 1'b0;
      end else begin
         r_rf_we <= w_wr_en;
         if (w_wr_en) begin
            r_rf_rd    <= w_sel_rd;
            r_rf_wdata <= w_sel_data;
         end
         if ((w_accept && !w_sel_in_range) || (i_issue_valid && !w_issue_in_range)) begin
            r_idx_err <= 1'b1;
         end
      end
   end

   // A new issue to a register outranks the completing write of an older
   // producer of the same register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= '0;
      end else begin
         r_busy[0] <= 1'b0;
         for (int i = 1; i < NUM_REGS; i++) begin
            if (w_issue_set && (i_issue_rd == ADDR_W'(i))) begin
               r_busy[i] <= 1'b1;
            end else if (r_rf_we && (r_rf_rd == ADDR_W'(i))) begin
               r_busy[i] <= 1'b0;
            end
         end
      end
   end

   // Index compare over the tracked range keeps out-of-range sources at 0.
   always_comb begin
      w_stall = 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (r_busy[i] && ((i_chk_rs1 == ADDR_W'(i)) || (i_chk_rs2 == ADDR_W'(i)))) begin
            w_stall = 1'b1;
         end
      end
   end

   assign o_stall    = w_stall;
   assign o_rf_we    = r_rf_we;
   assign o_rf_rd    = r_rf_rd;
   assign o_rf_wdata = r_rf_wdata;
   assign o_idx_err  = r_idx_err;

endmodule
